// File: rtl/riscv_ctrl_pkg.sv
// Shared constants for the RV32I multicycle control path.
package riscv_ctrl_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCA_PC   = 2'b00;
  localparam logic [1:0] SRCA_REGA = 2'b01;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BIMM = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_TRAP      = 4'd15
  } state_e;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle controller and the datapath.
interface multicycle_ctrl_if #(
  parameter int unsigned CNT_W = 32
);

  logic             en;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             i_or_d;
  logic             mem_to_reg;
  logic [1:0]       alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic             instr_retired;
  logic [CNT_W-1:0] retired_count;
  logic             illegal_instr;
  logic [3:0]       state;

  // Controller side
  modport master (
    input  en, opcode, mem_ready,
    output pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           i_or_d, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_retired, retired_count, illegal_instr, state
  );

  // Datapath side
  modport slave (
    output en, opcode, mem_ready,
    input  pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
           i_or_d, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
           instr_retired, retired_count, illegal_instr, state
  );

endinterface

// File: rtl/retire_counter.sv
// Wrapping count of retired instructions.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  // Increment once per retire pulse; natural overflow provides the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences ALU, memory, PC and register file.
module multicycle_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);

  state_e r_state;
  state_e w_next_state;
  logic   w_retire;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and Moore output decode; only the memory-wait states look at mem_ready
  always_comb begin
    w_next_state      = r_state;
    w_retire          = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = SRCA_PC;
    bus.alu_src_b     = SRCB_REGB;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_source     = PCSRC_ALU;
    bus.illegal_instr = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.en) w_next_state = S_FETCH;
      end
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_a = SRCA_PC;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALUOP_ADD;
        bus.pc_source = PCSRC_ALU;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) w_next_state = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_BIMM;
        case (bus.opcode)
          OP_RTYPE:           w_next_state = S_EXECUTE;
          OP_LOAD, OP_STORE:  w_next_state = S_MEM_ADDR;
          OP_BRANCH:          w_next_state = S_BRANCH;
          default:            w_next_state = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        bus.alu_src_a = SRCA_REGA;
        bus.alu_src_b = SRCB_IMM;
        w_next_state  = (bus.opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) w_next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        w_retire       = 1'b1;
      end
      S_MEM_WRITE: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        w_retire      = bus.mem_ready;
      end
      S_EXECUTE: begin
        bus.alu_src_a = SRCA_REGA;
        bus.alu_src_b = SRCB_REGB;
        bus.alu_op    = ALUOP_FUNC;
        w_next_state  = S_ALU_WB;
      end
      S_ALU_WB: begin
        bus.reg_write = 1'b1;
        w_retire      = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = SRCA_REGA;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        w_retire          = 1'b1;
      end
      S_TRAP: begin
        bus.illegal_instr = 1'b1;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase

    // en is only honoured at the instruction boundary
    if (w_retire) w_next_state = bus.en ? S_FETCH : S_IDLE;
  end

  assign bus.instr_retired = w_retire;
  assign bus.state         = STATE_W'(r_state);

  // Retired-instruction counter
  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_retire),
    .o_count (bus.retired_count)
  );

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl (narrow counter to reach the wrap).
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam logic [3:0] T_IDLE = 4'd0, T_FETCH = 4'd1, T_DECODE = 4'd2, T_MADDR = 4'd3,
                         T_MREAD = 4'd4, T_MWB = 4'd5, T_MWRITE = 4'd6, T_EXEC = 4'd7,
                         T_ALUWB = 4'd8, T_BRANCH = 4'd9, T_TRAP = 4'd15;

  localparam logic [6:0] C_RTYPE = 7'b0110011, C_LOAD = 7'b0000011, C_STORE = 7'b0100011,
                         C_BEQ = 7'b1100011, C_ILLEGAL = 7'b0010011;

  typedef struct packed {
    logic             pc_write;
    logic             pc_write_cond;
    logic             ir_write;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             i_or_d;
    logic             mem_to_reg;
    logic [1:0]       src_a;
    logic [1:0]       src_b;
    logic [1:0]       alu_op;
    logic [1:0]       pc_src;
    logic             retired;
    logic             illegal;
    logic [3:0]       st;
    logic [CNT_W-1:0] cnt;
  } obs_t;

  typedef struct {
    logic       en;
    logic       mr;
    logic [6:0] op;
    obs_t       exp;
  } step_t;

  logic clk;
  logic rst;
  obs_t w_obs;
  step_t q[$];
  logic [CNT_W-1:0] m_cnt;
  int n_pass;
  int n_total;

  multicycle_ctrl_if #(.CNT_W(CNT_W)) bus ();

  multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign w_obs = {bus.pc_write, bus.pc_write_cond, bus.ir_write, bus.reg_write,
                  bus.mem_read, bus.mem_write, bus.i_or_d, bus.mem_to_reg,
                  bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.pc_source,
                  bus.instr_retired, bus.illegal_instr, bus.state, bus.retired_count};

  // Reference output table per state
  function automatic obs_t exp_out(input logic [3:0] st, input logic mr);
    obs_t o;
    o = '0;
    o.st = st;
    case (st)
      T_FETCH:  begin o.mem_read = 1'b1; o.src_b = 2'b01; o.ir_write = mr; o.pc_write = mr; end
      T_DECODE: o.src_b = 2'b11;
      T_MADDR:  begin o.src_a = 2'b01; o.src_b = 2'b10; end
      T_MREAD:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
      T_MWB:    begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; o.retired = 1'b1; end
      T_MWRITE: begin o.mem_write = 1'b1; o.i_or_d = 1'b1; o.retired = mr; end
      T_EXEC:   begin o.src_a = 2'b01; o.alu_op = 2'b10; end
      T_ALUWB:  begin o.reg_write = 1'b1; o.retired = 1'b1; end
      T_BRANCH: begin o.src_a = 2'b01; o.alu_op = 2'b01; o.pc_write_cond = 1'b1;
                      o.pc_src = 2'b01; o.retired = 1'b1; end
      T_TRAP:   o.illegal = 1'b1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input logic [3:0] st, input logic mr, input logic e, input logic [6:0] op);
    step_t s;
    s.en  = e;
    s.mr  = mr;
    s.op  = op;
    s.exp = exp_out(st, mr);
    s.exp.cnt = m_cnt;
    q.push_back(s);
    if (s.exp.retired) m_cnt = m_cnt + CNT_W'(1);
  endtask

  // Expected cycle sequence for one instruction; e_mid is en from DECODE onward
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic e_mid);
    for (int i = 0; i < fw; i++) push(T_FETCH, 1'b0, 1'b1, op);
    push(T_FETCH, 1'b1, 1'b1, op);
    push(T_DECODE, 1'($urandom), e_mid, op);
    case (op)
      C_RTYPE: begin
        push(T_EXEC, 1'($urandom), e_mid, op);
        push(T_ALUWB, 1'($urandom), e_mid, op);
      end
      C_LOAD: begin
        push(T_MADDR, 1'($urandom), e_mid, op);
        for (int i = 0; i < mw; i++) push(T_MREAD, 1'b0, e_mid, op);
        push(T_MREAD, 1'b1, e_mid, op);
        push(T_MWB, 1'($urandom), e_mid, op);
      end
      C_STORE: begin
        push(T_MADDR, 1'($urandom), e_mid, op);
        for (int i = 0; i < mw; i++) push(T_MWRITE, 1'b0, e_mid, op);
        push(T_MWRITE, 1'b1, e_mid, op);
      end
      C_BEQ:   push(T_BRANCH, 1'($urandom), e_mid, op);
      default: push(T_TRAP, 1'($urandom), e_mid, op);
    endcase
  endtask

  task automatic check(input obs_t exp, input string tag);
    n_total++;
    assert (w_obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (state obs %0d exp %0d)",
                tag, w_obs, exp, w_obs.st, exp.st);
  endtask

  // Drive each queued step, sample mid-cycle, compare against the popped expectation
  task automatic run_queue(input string tag);
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.en        = s.en;
      bus.mem_ready = s.mr;
      bus.opcode    = s.op;
      @(negedge clk);
      check(s.exp, tag);
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    obs_t zero;
    obs_t fw;
    zero     = '0;
    n_pass   = 0;
    n_total  = 0;
    m_cnt    = '0;
    rst      = 1'b1;
    bus.en        = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 7'd0;
    #3;
    check(zero, "reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // R-type, LW with 3 read waits, BEQ, SW with en dropped mid-instruction
    push(T_IDLE, 1'b1, 1'b1, 7'd0);
    add_instr(C_RTYPE, 0, 0, 1'b1);
    add_instr(C_LOAD, 0, 3, 1'b1);
    add_instr(C_BEQ, 0, 0, 1'b1);
    add_instr(C_STORE, 1, 1, 1'b0);
    push(T_IDLE, 1'b1, 1'b0, 7'd0);
    run_queue("mix");

    // Twelve more branches: the 16th retirement wraps the 4-bit count to 0
    push(T_IDLE, 1'b0, 1'b1, 7'd0);
    for (int i = 0; i < 12; i++) add_instr(C_BEQ, 0, 0, (i != 11));
    push(T_IDLE, 1'b1, 1'b0, 7'd0);
    run_queue("wrap");

    // Illegal opcode traps and stays regardless of en/mem_ready
    push(T_IDLE, 1'b0, 1'b1, 7'd0);
    add_instr(C_ILLEGAL, 0, 0, 1'b1);
    for (int i = 0; i < 11; i++) push(T_TRAP, 1'($urandom), 1'($urandom), C_ILLEGAL);
    run_queue("trap");

    // Asynchronous reset out of TRAP
    #2;
    rst = 1'b1;
    #1;
    check(zero, "rst_trap");
    @(posedge clk);
    #1;
    rst   = 1'b0;
    m_cnt = '0;

    // Reset in the middle of a FETCH memory wait
    push(T_IDLE, 1'b0, 1'b1, C_RTYPE);
    push(T_FETCH, 1'b0, 1'b1, C_RTYPE);
    push(T_FETCH, 1'b0, 1'b1, C_RTYPE);
    run_queue("fetch_wait");
    bus.mem_ready = 1'b0;
    #2;
    fw = exp_out(T_FETCH, 1'b0);
    fw.cnt = m_cnt;
    check(fw, "fetch_hold");
    #1;
    rst = 1'b1;
    #1;
    check(zero, "rst_fetch");
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(T_IDLE, 1'b1, 1'b0, C_RTYPE);
    push(T_IDLE, 1'b0, 1'b0, C_RTYPE);
    run_queue("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control FSM for the RV32I subset core (R-type, LW, SW, BEQ). It sequences the shared ALU, memory port, PC and register file, and drives the 2-bit ALUOp into the ALU-control decoder. The ALUOp encoding is: 00 = add, 01 = subtract, 10 = decode from funct7/funct3. It also handles variable-latency memory through a ready handshake, counts retired instructions, and traps on illegal opcodes.

## Interface
- CNT_W, 32, width of the retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  run enable, sampled at instruction boundaries
- opcode  in  7  IR[6:0], valid from DECODE onward
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write, pc_write_cond, ir_write, reg_write  out  1 each  datapath write enables
- mem_read, mem_write  out  1 each  memory request
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  2  00 = PC, 01 = regA
- alu_src_b  out  2  00 = regB, 01 = const 4, 10 = I/S immediate, 11 = B immediate
- alu_op  out  2  ALUOp to the ALU-control decoder
- pc_source  out  2  00 = ALU result, 01 = ALUOut
- instr_retired  out  1  one-cycle pulse per completed instruction
- retired_count  out  CNT_W  wrapping retired-instruction count
- illegal_instr  out  1  sticky trap flag
- state  out  4  current state code (debug)

## Operation
- Moore FSM with a registered state. All outputs except the mem_ready-qualified ones are pure functions of state. Outputs not listed for a state are 0.
- IDLE: all outputs 0. Go to FETCH when en=1.
- FETCH:
  - Drives mem_read=1, i_or_d=0, alu_src_a=00, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write equal mem_ready.
  - Holds until mem_ready=1, then goes to DECODE.
- DECODE:
  - Drives alu_src_a=00, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state: opcode 0110011 → EXECUTE; 0000011 or 0100011 → MEM_ADDR; 1100011 → BRANCH; any other → TRAP.
- MEM_ADDR: alu_src_a=01, alu_src_b=10, alu_op=00. Go to MEM_READ on LW, MEM_WRITE on SW.
- MEM_READ: mem_read=1, i_or_d=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1. Retires.
- MEM_WRITE: mem_write=1, i_or_d=1. Hold until mem_ready; retires in the mem_ready cycle.
- EXECUTE: alu_src_a=01, alu_src_b=00, alu_op=10. Go to ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. Retires.
- BRANCH: alu_src_a=01, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Retires.
- Retire cycle:
  - instr_retired=1 and retired_count increments. The count wraps from 2^CNT_W−1 to 0.
  - Next state is FETCH if en=1, else IDLE.
  - en is ignored mid-instruction.
- TRAP: illegal_instr=1, all other outputs 0. Stays in TRAP until rst; en has no effect.
- State codes: IDLE=0, FETCH=1, DECODE=2, MEM_ADDR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXECUTE=7, ALU_WB=8, BRANCH=9, TRAP=15. Unused codes go to IDLE.

## Timing
- Reset (asynchronous, any time, including mid memory wait): state=IDLE, retired_count=0, illegal_instr=0, every output 0 immediately. The pending memory request is dropped.
- Cycles per instruction with zero-wait memory (mem_ready=1 on the first request cycle), FETCH through retire:
  - BEQ 3
  - R-type 4
  - SW 4
  - LW 5
- Each wait cycle (mem_ready=0 in FETCH, MEM_READ or MEM_WRITE) adds one cycle. Request signals stay stable for the whole wait.
- mem_ready is ignored outside FETCH, MEM_READ and MEM_WRITE.
- Back-to-back instructions: a retire cycle with en=1 is followed directly by FETCH, with no bubble.
- retired_count updates on the clock edge ending the retire cycle, so it is visible the cycle after the instr_retired pulse.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH)
  - ALUOp constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10)
  - alu_src_a/alu_src_b/pc_source select constants
  - the state encoding
- One sub-module, retire_counter (CNT_W-wide wrapping counter with increment enable and asynchronous reset). The FSM and output decode stay in multicycle_ctrl.

## Test plan
- Reset, then en=1, R-type opcode, mem_ready always 1 → states 1,2,7,8,1. alu_op=10 in EXECUTE, reg_write=1 only in ALU_WB, instr_retired pulses once, retired_count=1.
- LW with mem_ready low for 3 cycles in MEM_READ → mem_read=1 and i_or_d=1 held for 4 cycles. Total 8 cycles. mem_to_reg=1 in MEM_WB.
- BEQ → 3 cycles. In BRANCH: pc_write_cond=1, alu_op=01, pc_source=01. DECODE shows alu_src_b=11.
- Opcode 0010011 in DECODE → TRAP (state=15), illegal_instr=1 held for 10+ cycles, no instr_retired. rst clears it to IDLE.
- en dropped mid-SW → the store completes and retires, then IDLE. rst asserted during a FETCH wait → all outputs 0 at once.
- Preload retired_count to all-ones (CNT_W=4, 15 retirements) → the 16th retirement wraps it to 0.
